// File: rtl/bconv_pkg.sv
// Shared constants and width helpers for the binary-convolution row blocks.
package bconv_pkg;

  localparam int BCONV_TAPS   = 4;
  localparam int BCONV_ADDR_W = 12;
  localparam int BCONV_IDX_W  = 4;

  function automatic int bconv_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // neg_count spans 0..taps inclusive
  function automatic int bconv_cnt_w(input int taps);
    return bconv_clog2(taps + 1);
  endfunction

endpackage

// File: rtl/bconv_popcount.sv
// Combinational population count of a TAPS-wide vector; shared by wider rows.
module bconv_popcount
  import bconv_pkg::*;
#(
  parameter int TAPS = BCONV_TAPS,
  localparam int CNT_W = bconv_cnt_w(TAPS)
) (
  input  logic [TAPS-1:0]  bits_in,
  output logic [CNT_W-1:0] count_out
);

  always_comb begin
    count_out = '0;
    for (int i = 0; i < TAPS; i++) begin
      count_out = count_out + CNT_W'(bits_in[i]);
    end
  end

endmodule

// File: rtl/bconv_tap_chain.sv
// One binary-convolution row: serial weight chain, sign-bit data window and a
// registered count of negative products with its thresholded sign and tags.
module bconv_tap_chain
  import bconv_pkg::*;
#(
  parameter int TAPS   = BCONV_TAPS,
  parameter int ADDR_W = BCONV_ADDR_W,
  parameter int IDX_W  = BCONV_IDX_W,
  parameter int THRESH = TAPS / 2,
  localparam int CNT_W = bconv_cnt_w(TAPS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic              in_valid,
  input  logic              data_in,
  input  logic              pipeline_idx_enable,
  input  logic [ADDR_W-1:0] write_addr_in,
  input  logic [IDX_W-1:0]  idx_in,
  input  logic              load_weight,
  input  logic              weight_in,
  output logic              weights_loaded,
  output logic              data_out,
  output logic              out_valid,
  output logic [CNT_W-1:0]  neg_count,
  output logic              negative_flag,
  output logic [ADDR_W-1:0] write_addr_out,
  output logic [IDX_W-1:0]  idx_out
);

  logic [TAPS-1:0]   w_q, w_d;
  logic [TAPS-1:0]   d_q, d_d;
  logic [TAPS-1:0]   v_q, v_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] tag_addr_q, tag_addr_d;
  logic [IDX_W-1:0]  tag_idx_q, tag_idx_d;
  logic [CNT_W-1:0]  neg_count_q, neg_count_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] write_addr_out_q, write_addr_out_d;
  logic [IDX_W-1:0]  idx_out_q, idx_out_d;
  logic              loaded;
  logic [CNT_W-1:0]  pop_cnt;

  assign loaded = (wcnt_q == CNT_W'(TAPS));

  bconv_popcount #(.TAPS(TAPS)) u_popcount (
    .bits_in  (w_q ^ d_q),
    .count_out(pop_cnt)
  );

  always_comb begin
    w_d              = w_q;
    d_d              = d_q;
    v_d              = v_q;
    wcnt_d           = wcnt_q;
    tag_addr_d       = tag_addr_q;
    tag_idx_d        = tag_idx_q;
    neg_count_d      = neg_count_q;
    out_valid_d      = out_valid_q;
    write_addr_out_d = write_addr_out_q;
    idx_out_d        = idx_out_q;

    // Weight loading owns the edge; a reload after a full set flushes the window.
    if (load_weight) begin
      w_d[0] = weight_in;
      for (int i = 1; i < TAPS; i++) w_d[i] = w_q[i-1];
      if (loaded) begin
        wcnt_d = CNT_W'(1);
        v_d    = '0;
      end else begin
        wcnt_d = wcnt_q + CNT_W'(1);
      end
    end else if (go) begin
      d_d[0] = data_in;
      v_d[0] = in_valid;
      for (int i = 1; i < TAPS; i++) begin
        d_d[i] = d_q[i-1];
        v_d[i] = v_q[i-1];
      end
      if (pipeline_idx_enable) begin
        tag_addr_d = write_addr_in;
        tag_idx_d  = idx_in;
      end
      neg_count_d      = pop_cnt;
      out_valid_d      = (&v_q) & loaded;
      write_addr_out_d = tag_addr_q;
      idx_out_d        = tag_idx_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_q              <= '0;
      d_q              <= '0;
      v_q              <= '0;
      wcnt_q           <= '0;
      tag_addr_q       <= '0;
      tag_idx_q        <= '0;
      neg_count_q      <= '0;
      out_valid_q      <= 1'b0;
      write_addr_out_q <= '0;
      idx_out_q        <= '0;
    end else begin
      w_q              <= w_d;
      d_q              <= d_d;
      v_q              <= v_d;
      wcnt_q           <= wcnt_d;
      tag_addr_q       <= tag_addr_d;
      tag_idx_q        <= tag_idx_d;
      neg_count_q      <= neg_count_d;
      out_valid_q      <= out_valid_d;
      write_addr_out_q <= write_addr_out_d;
      idx_out_q        <= idx_out_d;
    end
  end

  assign weights_loaded = loaded;
  assign data_out       = d_q[TAPS-1];
  assign out_valid      = out_valid_q;
  assign neg_count      = neg_count_q;
  assign negative_flag  = int'(neg_count_q) > THRESH;
  assign write_addr_out = write_addr_out_q;
  assign idx_out        = idx_out_q;

endmodule
